// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// bin2bcd_seq -- sequencer for a serial (shift-in) binary-to-BCD converter.
//
// Takes a binary word on a valid/ready handshake, pulses the converter clear
// for one cycle, shifts the word into the converter MSB first (one bit per
// clock), waits SETTLE clocks, captures the converter's BCD result and
// presents it on a valid/ready output until the consumer takes it.
//
// Parameters
//   NBIT    binary input width, also the number of shift cycles
//   NDIGIT  BCD digits in the result (result width 4*NDIGIT); must be able to
//           hold 2^NBIT-1, otherwise elaboration stops with an error
//   SETTLE  idle clocks after the last shifted bit before capture (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   abort      synchronous abort, active high; returns to IDLE on the next edge
//   in_valid   in_data valid
//   in_ready   sequencer can accept a word (registered)
//   in_data    unsigned binary value, NBIT bits
//   conv_clr   clear to the converter, active high (high while in reset)
//   conv_in    serial data to the converter, MSB first
//   conv_out   BCD result from the converter, 4*NDIGIT bits
//   out_valid  out_bcd valid
//   out_ready  consumer takes out_bcd
//   out_bcd    captured BCD result, digit 0 in [3:0]
//   busy       high in every state except IDLE
//
// Build option
//   BIN2BCD_SEQ_ZBLANK_EN  when defined, zero digits above the most
//   significant nonzero digit are replaced with 4'hF at capture. Digit 0 is
//   never blanked. When undefined, out_bcd is conv_out exactly as captured.

module bin2bcd_seq #(
  parameter int NBIT   = 24,
  parameter int NDIGIT = 8,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBIT-1:0]       in_data,
  output logic                  conv_clr,
  output logic                  conv_in,
  input  logic [4*NDIGIT-1:0]   conv_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NDIGIT-1:0]   out_bcd,
  output logic                  busy
);

  // One counter serves both the shift phase and the settle phase.
  localparam int CNT_MAX = (NBIT > SETTLE) ? NBIT : SETTLE;
  localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BIT_LAST    = CW'(NBIT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  // True when NDIGIT decimal digits can represent the largest NBIT value.
  function automatic bit digits_cover_range();
    logic [127:0] lim;
    lim = 128'd1;
    for (int k = 0; k < NDIGIT; k++) lim = lim * 128'd10;
    return lim > ((128'd1 << NBIT) - 128'd1);
  endfunction

  localparam bit CFG_OK = digits_cover_range();

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("bin2bcd_seq: NDIGIT too small for NBIT");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [NBIT-1:0]       shreg_reg, shreg_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  in_ready_reg, in_ready_next;
  logic                  conv_clr_reg, conv_clr_next;
  logic                  out_valid_reg, out_valid_next;
  logic [4*NDIGIT-1:0]   out_bcd_reg, out_bcd_next;
  logic [4*NDIGIT-1:0]   capture_val;
  logic                  accept;

  // An abort in the same cycle wins over an offered word.
  assign accept = in_valid && in_ready_reg && !abort;

`ifdef BIN2BCD_SEQ_ZBLANK_EN
  // lead_zero[d] is set when digit d and every digit above it are zero.
  // lead_zero[NDIGIT] is a virtual "nothing above the top digit" seed.
  logic [NDIGIT:1] lead_zero;
  assign lead_zero[NDIGIT]  = 1'b1;
  assign capture_val[3:0]   = conv_out[3:0];

  genvar gi;
  generate
    for (gi = 1; gi < NDIGIT; gi++) begin : g_blank
      assign lead_zero[gi] = (conv_out[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
      assign capture_val[4*gi +: 4] = lead_zero[gi] ? 4'hF : conv_out[4*gi +: 4];
    end
  endgenerate
`else
  assign capture_val = conv_out;
`endif

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_bcd_next   = out_bcd_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          shreg_next = in_data;
          cnt_next   = '0;
          state_next = S_CLR;
        end
      end
      S_CLR: begin
        cnt_next   = '0;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_next = shreg_reg << 1;
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = S_SETTLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          // conv_out already reflects all NBIT shifted bits here.
          out_bcd_next   = capture_val;
          out_valid_next = 1'b1;
          cnt_next       = '0;
          state_next     = S_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Abort drops any work in flight; the last captured result stays on out_bcd.
    if (abort) begin
      state_next     = S_IDLE;
      out_valid_next = 1'b0;
      cnt_next       = '0;
    end

    in_ready_next = (state_next == S_IDLE);
    conv_clr_next = abort || (state_next == S_CLR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      shreg_reg     <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b0;
      conv_clr_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_bcd_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      cnt_reg       <= cnt_next;
      in_ready_reg  <= in_ready_next;
      conv_clr_reg  <= conv_clr_next;
      out_valid_reg <= out_valid_next;
      out_bcd_reg   <= out_bcd_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign conv_clr  = conv_clr_reg;
  assign conv_in   = (state_reg == S_SHIFT) && shreg_reg[NBIT-1];
  assign out_valid = out_valid_reg;
  assign out_bcd   = out_bcd_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
// Bench for bin2bcd_seq: a default-size instance (24 bit / 8 digit) and a
// narrow instance (8 bit / 3 digit), each driving a behavioural serial
// double-dabble converter. Expected results go into a queue at accept time
// and are popped when the sequencer presents its output.

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default instance
  logic        abort, in_valid, in_ready, conv_clr, conv_in, out_valid, out_ready, busy;
  logic [23:0] in_data;
  logic [31:0] conv_out, out_bcd;

  // narrow instance
  logic        abort8, in_valid8, in_ready8, conv_clr8, conv_in8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_data8;
  logic [11:0] conv_out8, out_bcd8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb[$];
  logic [11:0] sb8[$];

  bin2bcd_seq u_dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .conv_clr(conv_clr), .conv_in(conv_in), .conv_out(conv_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .busy(busy)
  );

  bin2bcd_seq #(.NBIT(8), .NDIGIT(3), .SETTLE(1)) u_dut8 (
    .clk(clk), .rst(rst), .abort(abort8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .conv_clr(conv_clr8), .conv_in(conv_in8), .conv_out(conv_out8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_bcd(out_bcd8), .busy(busy8)
  );

  // Serial double-dabble step: add 3 to every digit >= 5, then shift the bit in.
  function automatic logic [31:0] dd_step(input logic [31:0] b, input logic s);
    logic [31:0] t;
    t = b;
    for (int k = 0; k < 8; k++)
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    return {t[30:0], s};
  endfunction

  always @(posedge clk) conv_out  <= conv_clr  ? 32'd0 : dd_step(conv_out, conv_in);
  always @(posedge clk) conv_out8 <= conv_clr8 ? 12'd0 : 12'(dd_step({20'd0, conv_out8}, conv_in8));

  // Reference result by repeated division, with optional leading-zero blanking.
  function automatic logic [31:0] exp_bcd(input int unsigned v, input int ndig);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < ndig; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_SEQ_ZBLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int k = ndig - 1; k >= 1; k--) begin
        if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word to the default instance and return one step after the accepting edge.
  task automatic send(input logic [23:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; n counts edges with the accepting edge as edge 1.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (conv_clr !== 1'b1) begin n_bad++; $display("FAIL reset_conv_clr: got %b want 1", conv_clr); end
    n_cmp++; if (conv_in !== 1'b0) begin n_bad++; $display("FAIL reset_conv_in: got %b want 0", conv_in); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bcd !== 32'd0) begin n_bad++; $display("FAIL reset_out_bcd: got %h want 0", out_bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (conv_clr8 !== 1'b1 || busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_narrow: clr %b busy %b want 1 0", conv_clr8, busy8); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL release_in_ready_low: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready_high: got %b want 1", in_ready); end
    n_cmp++; if (conv_clr !== 1'b0) begin n_bad++; $display("FAIL release_conv_clr: got %b want 0", conv_clr); end
    n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL release_in_ready8: got %b want 1", in_ready8); end
    $display("reset: released, in_ready=%b", in_ready);
  endtask

  task automatic test_narrow_serial();
    logic [7:0]  word;
    logic [11:0] exp;
    word = 8'd254;
    in_valid8 = 1'b1;
    in_data8  = word;
    for (int n = 0; n < 50 && !in_ready8; n++) tick();
    tick();                                   // accepting edge (edge 1)
    in_valid8 = 1'b0;
    sb8.push_back(12'h254);
    n_cmp++; if (conv_clr8 !== 1'b1 || conv_in8 !== 1'b0) begin n_bad++; $display("FAIL narrow_clr_cycle: clr %b in %b want 1 0", conv_clr8, conv_in8); end
    for (int i = 0; i < 8; i++) begin
      tick();                                 // edge 2+i, shift cycle i
      n_cmp++; if (conv_in8 !== word[7-i] || conv_clr8 !== 1'b0) begin n_bad++; $display("FAIL narrow_bit%0d: conv_in %b clr %b want %b 0", i, conv_in8, conv_clr8, word[7-i]); end
    end
    tick();                                   // edge 10, settle cycle
    n_cmp++; if (out_valid8 !== 1'b0 || conv_in8 !== 1'b0) begin n_bad++; $display("FAIL narrow_settle: out_valid %b conv_in %b want 0 0", out_valid8, conv_in8); end
    tick();                                   // edge 11
    exp = sb8.pop_front();
    n_cmp++; if (out_valid8 !== 1'b1) begin n_bad++; $display("FAIL narrow_latency: out_valid %b at edge 11 want 1", out_valid8); end
    n_cmp++; if (out_bcd8 !== exp) begin n_bad++; $display("FAIL narrow_result: got %h want %h", out_bcd8, exp); end
    $display("xfer narrow: in=%0d out_bcd=%h", word, out_bcd8);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_bad++; $display("FAIL narrow_release: out_valid %b in_ready %b want 0 1", out_valid8, in_ready8); end
  endtask

  task automatic test_max_hold();
    int n;
    logic [31:0] exp;
    send(24'd16777215);
    sb.push_back(exp_bcd(16777215, 8));
    wait_out(n);
    exp = sb.pop_front();
    n_cmp++; if (n !== 27) begin n_bad++; $display("FAIL max_latency: out_valid at edge %0d want 27", n); end
    n_cmp++; if (out_bcd !== exp) begin n_bad++; $display("FAIL max_result: got %h want %h", out_bcd, exp); end
    $display("xfer max: in=16777215 out_bcd=%h", out_bcd);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (out_bcd !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL max_hold%0d: bcd %h valid %b in_ready %b want %h 1 0", i, out_bcd, out_valid, in_ready, exp); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL max_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    logic [31:0] exp;
    send(24'hABCDEF);                          // edge 1: now in CLR
    repeat (4) tick();                        // shift cycle with bit counter = 3
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || conv_clr !== 1'b1) begin n_bad++; $display("FAIL abort_shift: busy %b valid %b clr %b want 0 0 1", busy, out_valid, conv_clr); end
    // abort together with an offered word in IDLE: the word must not be taken
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'd5;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_blocks_accept: busy %b want 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_output: out_valid seen %b want 0", seen); end
    send(24'd1);
    sb.push_back(exp_bcd(1, 8));
    wait_out(n);
    exp = sb.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out_bcd !== exp) begin n_bad++; $display("FAIL abort_next_word: valid %b bcd %h want 1 %h", out_valid, out_bcd, exp); end
    $display("xfer after_abort: in=1 out_bcd=%h", out_bcd);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] words [2];
    int acc [2];
    int idx, nclr, nout;
    logic [31:0] exp;
    words[0] = 24'd0;
    words[1] = 24'd9999999;
    idx = 0; nclr = 0; nout = 0;
    acc[0] = -1; acc[1] = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = words[0];
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (conv_clr) nclr++;
      if (in_valid && in_ready && idx < 2) begin
        acc[idx] = cyc;
        sb.push_back(exp_bcd(int'(words[idx]), 8));
        idx++;
      end
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        n_cmp++; if (out_bcd !== exp) begin n_bad++; $display("FAIL b2b_result%0d: got %h want %h", nout, out_bcd, exp); end
        $display("xfer b2b%0d: out_bcd=%h", nout, out_bcd);
        nout++;
      end
      tick();
      if (idx >= 2) in_valid = 1'b0;
      else in_data = words[idx];
    end
    out_ready = 1'b0;
    n_cmp++; if (acc[1] - acc[0] !== 28) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 28", acc[1] - acc[0]); end
    n_cmp++; if (nclr !== 2) begin n_bad++; $display("FAIL b2b_clr_pulses: got %0d want 2", nclr); end
    n_cmp++; if (nout !== 2) begin n_bad++; $display("FAIL b2b_outputs: got %0d want 2", nout); end
  endtask

  task automatic test_zblank();
    int n;
    logic [31:0] exp;
`ifdef BIN2BCD_SEQ_ZBLANK_EN
    sb.push_back(32'hFFFFFF42);
    sb.push_back(32'hFFFFFFF0);
`else
    sb.push_back(32'h00000042);
    sb.push_back(32'h00000000);
`endif
    for (int w = 0; w < 2; w++) begin
      send((w == 0) ? 24'd42 : 24'd0);
      wait_out(n);
      exp = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || out_bcd !== exp) begin n_bad++; $display("FAIL zblank%0d: valid %b bcd %h want 1 %h", w, out_valid, out_bcd, exp); end
      $display("xfer zblank%0d: out_bcd=%h", w, out_bcd);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    abort8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    test_reset();
    test_narrow_serial();
    test_max_hold();
    test_abort();
    test_back_to_back();
    test_zblank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
